// File: rtl/clb_slice_if.sv
// Signal bundle for one clb_slice: logic inputs, configuration chain and status.
// The design connects through the slave modport; whatever drives it uses master.
interface clb_slice_if #(
    parameter int K = 4,
    parameter int N = 2
);
    logic           prgm_b;
    logic           cfg_in;
    logic           cfg_out;
    logic           ce;
    logic [N*K-1:0] x;
    logic [N-1:0]   out;
    logic           cfg_done;
    logic           cfg_err;

    modport master (
        output prgm_b, cfg_in, ce, x,
        input  cfg_out, out, cfg_done, cfg_err
    );

    modport slave (
        input  prgm_b, cfg_in, ce, x,
        output cfg_out, out, cfg_done, cfg_err
    );
endinterface

// File: rtl/clb_slice.sv
// Configurable logic slice: N pairs of K-input LUT plus clock-enabled flip-flop,
// programmed MSB-first over a serial chain that daisy-chains out through cfg_out.
module clb_slice #(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    clb_slice_if.slave   bus
);
    localparam int LUTW  = 1 << K;
    localparam int W     = LUTW + 2;
    localparam int TOTAL = N * W;
    localparam int CW    = $clog2(TOTAL + 2);

    localparam logic [CW-1:0] COUNT_FULL = CW'(TOTAL);
    localparam logic [CW-1:0] COUNT_SAT  = CW'(TOTAL + 1);

    typedef enum logic [1:0] {
        UNCFG,
        LOAD,
        CFG,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [TOTAL-1:0] cfg_q, cfg_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N-1:0]     ff_q, ff_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [N-1:0]     lutOut;
    logic [N-1:0]     outSel;
    logic [N-1:0]     ffInit;

    // Each pair's slice of the chain is {ff_init, out_sel, truth table}.
    for (genvar i = 0; i < N; i++) begin : g_pair
        logic [W-1:0]    pairCfg;
        logic [LUTW-1:0] lut;
        logic [K-1:0]    addr;

        assign pairCfg   = cfg_q[i*W +: W];
        assign lut       = pairCfg[LUTW-1:0];
        assign addr      = bus.x[i*K +: K];
        assign lutOut[i] = lut[addr];
        assign outSel[i] = pairCfg[LUTW];
        assign ffInit[i] = pairCfg[LUTW+1];
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        count_d = count_q;
        ff_d    = ff_q;
        done_d  = done_q;
        err_d   = err_q;

        // A low prgm_b always wins, even over ce in CFG, so FFs stay put while shifting.
        if (!bus.prgm_b) begin
            cfg_d   = {cfg_q[TOTAL-2:0], bus.cfg_in};
            state_d = LOAD;
            done_d  = 1'b0;
            err_d   = 1'b0;
            if (state_q == LOAD) begin
                count_d = (count_q == COUNT_SAT) ? count_q : count_q + 1'b1;
            end else begin
                count_d = CW'(1);
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (count_q == COUNT_FULL) begin
                        state_d = CFG;
                        done_d  = 1'b1;
                        ff_d    = ffInit;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                CFG: begin
                    if (bus.ce) begin
                        ff_d = lutOut;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNCFG;
            cfg_q   <= '0;
            count_q <= '0;
            ff_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            count_q <= count_d;
            ff_q    <= ff_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are silent until a complete stream has been accepted.
    assign bus.out      = (state_q == CFG) ? ((outSel & ff_q) | (~outSel & lutOut)) : '0;
    assign bus.cfg_out  = cfg_q[TOTAL-1];
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_clb_slice.sv
// Randomised scoreboard bench for clb_slice: a bit-history reference model predicts
// each cycle's outputs, and a negedge monitor pops and compares them.
module tb_clb_slice;
    localparam int K     = 4;
    localparam int N     = 2;
    localparam int LUTW  = 1 << K;
    localparam int W     = LUTW + 2;
    localparam int TOTAL = N * W;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    clb_slice_if #(.K(K), .N(N)) bus ();

    clb_slice #(.K(K), .N(N)) dut (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [N-1:0] out;
        logic         done;
        logic         err;
        logic         cfgOut;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model: every bit ever shifted since reset, newest at the back.
    bit           hist[$];
    bit           loading;
    bit           configured;
    bit           errored;
    int           streamLen;
    logic [N-1:0] ffM;

    function automatic bit cfgBit(int p);
        if (hist.size() > p) return hist[hist.size() - 1 - p];
        return 1'b0;
    endfunction

    function automatic bit lutOf(int i, logic [N*K-1:0] xv);
        int addr;
        addr = int'((xv >> (i * K)) & ((1 << K) - 1));
        return cfgBit(i * W + addr);
    endfunction

    task automatic modelReset();
        hist.delete();
        loading    = 1'b0;
        configured = 1'b0;
        errored    = 1'b0;
        streamLen  = 0;
        ffM        = '0;
    endtask

    task automatic modelEdge(logic prgm, logic cin, logic ceV, logic [N*K-1:0] xv);
        if (!prgm) begin
            hist.push_back(cin);
            streamLen  = loading ? streamLen + 1 : 1;
            loading    = 1'b1;
            configured = 1'b0;
            errored    = 1'b0;
        end else if (loading) begin
            loading = 1'b0;
            if (streamLen == TOTAL) begin
                configured = 1'b1;
                for (int i = 0; i < N; i++) ffM[i] = cfgBit(i * W + LUTW + 1);
            end else begin
                errored = 1'b1;
            end
        end else if (configured && ceV) begin
            for (int i = 0; i < N; i++) ffM[i] = lutOf(i, xv);
        end
    endtask

    task automatic pushExpect(string tag);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (!configured)                 e.out[i] = 1'b0;
            else if (cfgBit(i * W + LUTW))   e.out[i] = ffM[i];
            else                             e.out[i] = lutOf(i, bus.x);
        end
        e.done   = configured;
        e.err    = errored;
        e.cfgOut = cfgBit(TOTAL - 1);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic applyStimulus(logic prgm, logic cin, logic ceV, logic [N*K-1:0] xv, string tag);
        @(posedge clk);
        if (resetN) modelEdge(bus.prgm_b, bus.cfg_in, bus.ce, bus.x);
        #1;
        bus.prgm_b = prgm;
        bus.cfg_in = cin;
        bus.ce     = ceV;
        bus.x      = xv;
        pushExpect(tag);
    endtask

    task automatic sendBits(logic [127:0] v, int n, string tag);
        for (int p = n - 1; p >= 0; p--) begin
            applyStimulus(1'b0, v[p], 1'($urandom), (N*K)'($urandom), tag);
        end
    endtask

    task automatic operate(int cycles, string tag);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), (N*K)'($urandom), tag);
        end
    endtask

    task automatic asyncReset(string tag);
        @(posedge clk);
        if (resetN) modelEdge(bus.prgm_b, bus.cfg_in, bus.ce, bus.x);
        #3;
        resetN = 1'b0;
        modelReset();
        pushExpect(tag);
        @(posedge clk);
        #1;
        resetN     = 1'b1;
        bus.prgm_b = 1'b1;
        pushExpect(tag);
    endtask

    task automatic checkOutput(exp_t e, string tag);
        vectors++;
        if ({bus.out, bus.cfg_done, bus.cfg_err, bus.cfg_out} !== {e.out, e.done, e.err, e.cfgOut}) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got out=%b done=%b err=%b cfg_out=%b, expected out=%b done=%b err=%b cfg_out=%b",
                     tag, $time, bus.out, bus.cfg_done, bus.cfg_err, bus.cfg_out,
                     e.out, e.done, e.err, e.cfgOut);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t  e;
            string t;
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(e, t);
        end
    end

    logic [TOTAL-1:0] cfgA;
    logic [127:0]     rnd;

    initial begin
        resetN     = 1'b1;
        bus.prgm_b = 1'b1;
        bus.cfg_in = 1'b0;
        bus.ce     = 1'b0;
        bus.x      = '0;
        modelReset();
        #1 resetN = 1'b0;

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), (N*K)'($urandom), "reset_state");
        end
        bus.prgm_b = 1'b1;
        resetN     = 1'b1;
        operate(4, "unconfigured");

        // Pair 0: AND4, combinational. Pair 1: XOR4, registered, ff_init=1.
        cfgA = {1'b1, 1'b1, 16'h6996, 1'b0, 1'b0, 16'h8000};
        sendBits({92'b0, cfgA}, TOTAL, "load_a");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "cfg_done");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, "and4_comb");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, "xor_ce");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, "xor_reg");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h70, "ce_hold");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, "ce_on");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, "ce_update");
        operate(30, "run_a");

        rnd = {$urandom, $urandom, $urandom, $urandom};
        sendBits(rnd, TOTAL - 1, "short_stream");
        operate(3, "short_err");
        rnd = {$urandom, $urandom, $urandom, $urandom};
        sendBits(rnd, TOTAL + 4, "long_stream");
        operate(3, "long_err");
        rnd = {$urandom, $urandom, $urandom, $urandom};
        sendBits(rnd, TOTAL, "recover_stream");
        operate(30, "run_recover");

        rnd = {$urandom, $urandom, $urandom, $urandom};
        sendBits(rnd, 2 * TOTAL, "chain_pass");
        operate(3, "chain_err");

        rnd = {$urandom, $urandom, $urandom, $urandom};
        sendBits(rnd, 20, "partial_stream");
        asyncReset("async_reset");
        sendBits({92'b0, cfgA}, TOTAL, "reload_a");
        operate(20, "run_reload");

        for (int r = 0; r < 3; r++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            sendBits(rnd, TOTAL, "rand_cfg");
            operate(25, "rand_run");
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clb_slice.md
Name: clb_slice

Overview:
- Parametrised configurable logic slice holding N LUT/flip-flop pairs.
- Each pair has a K-input LUT, a D flip-flop with clock enable, and a LUT/FF output select.
- Configuration arrives over a serial chain gated by prgm_b, and the slice tracks its own configured/error status.
- Instantiated inside CLBs; cfg_out daisy-chains to the next slice in the fabric bitstream chain.

Parameters:
- K, 4, LUT input count per pair (LUT depth 2^K).
- N, 2, number of LUT/FF pairs in the slice.
- Derived: W = 2^K + 2, configuration bits per pair.
- Derived: TOTAL = N*W, chain length (default 36).

Ports:
- clk  input  1  fabric clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- prgm_b  input  1  active-low program enable; low = shift configuration.
- cfg_in  input  1  serial configuration bit, sampled while prgm_b=0.
- cfg_out  output  1  chain output, equal to cfg_reg[TOTAL-1].
- ce  input  1  flip-flop clock enable, common to all pairs.
- x  input  N*K  logic inputs; pair i uses x[i*K +: K] as its LUT address.
- out  output  N  pair outputs.
- cfg_done  output  1  high in state CFG.
- cfg_err  output  1  high in state ERR.

Behaviour:
- Config layout for pair i, base b = i*W:
  - cfg_reg[b +: 2^K] is the LUT truth table; entry index = address.
  - cfg_reg[b+2^K] is out_sel: 1 = registered output, 0 = combinational.
  - cfg_reg[b+2^K+1] is ff_init.
- Reset (reset=0, async): cfg_reg=0, state=UNCFG, count=0, all FFs=0, out=0, cfg_done=0, cfg_err=0, cfg_out=0.
- State UNCFG / CFG / ERR, any cycle with prgm_b=0:
  - Shift cfg_reg <= {cfg_reg[TOTAL-2:0], cfg_in}.
  - count <= 1.
  - Go to LOAD.
- State LOAD:
  - prgm_b=0: shift; count <= count+1, saturating at TOTAL+1.
  - prgm_b=1 and count==TOTAL: go to CFG; every pair FF loads its ff_init on that same edge.
  - prgm_b=1 and count!=TOTAL (short or long stream): go to ERR; cfg_reg holds its contents.
- Bit order: the first bit shifted in ends at cfg_reg[TOTAL-1] after exactly TOTAL shifts, i.e. the MSB is sent first.
- State CFG:
  - LUT output for pair i = lut_i[x_i].
  - FF_i <= lut_i[x_i] on an edge with ce=1; holds when ce=0.
  - out[i] = out_sel_i ? FF_i : lut_i[x_i].
- States UNCFG, LOAD, ERR:
  - out forced to 0.
  - FFs hold their value and ignore ce.
- Re-programming from CFG (prgm_b falls):
  - cfg_done drops on that edge.
  - out goes to 0 from the next cycle until the new configuration completes.
- Latency:
  - Combinational path x->out has zero cycles.
  - Registered path: out changes one edge after ce=1.
  - cfg_done/cfg_err assert one edge after prgm_b rises.
- cfg_out is registered, not gated by state, so bits pass through the chain continuously.
- Reset asserted mid-LOAD aborts the stream: return to UNCFG with cfg_reg cleared.
- prgm_b=0 coinciding with ce=1 in CFG: the state change wins; FFs do not update.
- All state updates are clean at the boundaries; count never wraps.

Test Plan:
- Reset-state check: K=4, N=2, reset low -> out=2'b00, cfg_done=0, cfg_err=0, cfg_out=0.
- Normal configuration:
  - Stimulus: shift 36 bits; pair0 LUT=16'h8000 (AND4), out_sel=0; pair1 LUT=16'h6996 (XOR4), out_sel=1, ff_init=1; then raise prgm_b.
  - Required: cfg_done=1 next edge; out[1]=1 from ff_init.
  - x=8'hFF -> out[0]=1 with no delay.
  - x[7:4]=4'h1, ce=1 -> out[1]=1 after one edge.
- Clock enable hold: configured as above, ce=0, x[7:4] toggled -> out[1] holds; ce=1 -> out[1] updates on the next edge.
- Short and long streams: 35 bits then prgm_b=1 -> cfg_err=1, out=0; 40 bits -> cfg_err=1; then a correct 36-bit stream -> cfg_done=1, cfg_err=0.
- Chain passthrough: shift 72 bits -> cfg_out replays the first 36 input bits, delayed by 36 cycles.
- Asynchronous reset in LOAD: reset pulsed low mid-stream (between edges) -> immediate UNCFG, cfg_reg=0; the next full stream configures correctly.
